// File: rtl/rob_multi_commit_if.sv
// Reorder buffer bundle: dispatch allocation, CDB writeback and multi-lane retirement.
interface rob_multi_commit_if #(
    parameter int ROB_DEPTH     = 16,
    parameter int PHYS_REG_BITS = 6,
    parameter int COMMIT_WIDTH  = 2,
    parameter int CDB_PORTS     = 2
);
    localparam int IDXW = $clog2(ROB_DEPTH);

    logic                            enq_valid;
    logic                            enq_ready;
    logic [31:0]                     enq_pc;
    logic [31:0]                     enq_inst;
    logic [4:0]                      enq_arch_rd;
    logic [PHYS_REG_BITS-1:0]        enq_phys_rd;
    logic [IDXW-1:0]                 enq_index;
    logic [CDB_PORTS-1:0]            cdb_valid;
    logic [CDB_PORTS*IDXW-1:0]       cdb_rob_index;
    logic [CDB_PORTS-1:0]            cdb_branch_mismatch;
    logic                            commit_stall;
    logic [COMMIT_WIDTH-1:0]         commit_valid;
    logic [COMMIT_WIDTH*5-1:0]       commit_arch_rd;
    logic [COMMIT_WIDTH*PHYS_REG_BITS-1:0] commit_phys_rd;
    logic [COMMIT_WIDTH*32-1:0]      commit_pc;
    logic [COMMIT_WIDTH*32-1:0]      commit_inst;
    logic                            flush;
    logic [IDXW:0]                   count;

    modport slave (
        input  enq_valid, enq_pc, enq_inst, enq_arch_rd, enq_phys_rd,
        input  cdb_valid, cdb_rob_index, cdb_branch_mismatch, commit_stall,
        output enq_ready, enq_index, commit_valid, commit_arch_rd, commit_phys_rd,
        output commit_pc, commit_inst, flush, count
    );

    modport master (
        output enq_valid, enq_pc, enq_inst, enq_arch_rd, enq_phys_rd,
        output cdb_valid, cdb_rob_index, cdb_branch_mismatch, commit_stall,
        input  enq_ready, enq_index, commit_valid, commit_arch_rd, commit_phys_rd,
        input  commit_pc, commit_inst, flush, count
    );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocation, CDB completion marking, up to COMMIT_WIDTH
// in-order retirements per cycle, and a full flush when a retiring entry mispredicted.
module rob_multi_commit #(
    parameter int ROB_DEPTH     = 16,
    parameter int PHYS_REG_BITS = 6,
    parameter int COMMIT_WIDTH  = 2,
    parameter int CDB_PORTS     = 2
) (
    input  logic              clk,
    input  logic              rst,
    rob_multi_commit_if.slave bus
);
    localparam int IDXW = $clog2(ROB_DEPTH);
    localparam int PTRW = IDXW + 1;

    logic [PTRW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [ROB_DEPTH-1:0]     valid_q, valid_d, done_q, done_d, mis_q, mis_d;
    logic [31:0]              pc_q   [ROB_DEPTH];
    logic [31:0]              inst_q [ROB_DEPTH];
    logic [4:0]               arch_q [ROB_DEPTH];
    logic [PHYS_REG_BITS-1:0] phys_q [ROB_DEPTH];

    logic [PTRW-1:0]          occ;
    logic [IDXW-1:0]          tail_idx;
    logic                     full, enq_ready, enq_fire, flush;
    logic [COMMIT_WIDTH-1:0]  lane_vld;
    logic [IDXW-1:0]          lane_idx [COMMIT_WIDTH];
    logic [PTRW-1:0]          ncommit;
    logic [COMMIT_WIDTH*5-1:0]             c_arch;
    logic [COMMIT_WIDTH*PHYS_REG_BITS-1:0] c_phys;
    logic [COMMIT_WIDTH*32-1:0]            c_pc;
    logic [COMMIT_WIDTH*32-1:0]            c_inst;

    // Occupancy and fullness come from the wrap-bit pointers only; a same-cycle
    // commit never opens a slot for the enqueue.
    assign occ       = tail_q - head_q;
    assign tail_idx  = tail_q[IDXW-1:0];
    assign full      = (tail_q[IDXW] != head_q[IDXW]) && (tail_idx == head_q[IDXW-1:0]);
    assign enq_ready = !rst && !full && !flush;
    assign enq_fire  = bus.enq_valid && enq_ready;

    // Retirement selection: walk lanes from the oldest entry, stopping at the first
    // not-done entry, or right after a mispredicted one (which still retires).
    always_comb begin
        logic chain;
        chain    = !rst && !bus.commit_stall;
        lane_vld = '0;
        lane_idx = '{default: '0};
        flush    = 1'b0;
        ncommit  = '0;
        c_arch   = '0;
        c_phys   = '0;
        c_pc     = '0;
        c_inst   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            lane_idx[i] = head_q[IDXW-1:0] + IDXW'(i);
            if (chain && (PTRW'(i) < occ) && done_q[lane_idx[i]]) begin
                lane_vld[i] = 1'b1;
                ncommit     = ncommit + PTRW'(1);
                c_arch[i*5 +: 5]                     = arch_q[lane_idx[i]];
                c_phys[i*PHYS_REG_BITS +: PHYS_REG_BITS] = phys_q[lane_idx[i]];
                c_pc[i*32 +: 32]                     = pc_q[lane_idx[i]];
                c_inst[i*32 +: 32]                   = inst_q[lane_idx[i]];
                if (mis_q[lane_idx[i]]) begin
                    flush = 1'b1;
                    chain = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
    end

    // Next-state bookkeeping: writeback marks, retirement and allocation; a flush
    // discards every entry and drops this cycle's enqueue and writebacks.
    always_comb begin
        logic [IDXW-1:0] cidx;
        cidx    = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        mis_d   = mis_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
            mis_d   = '0;
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                cidx = bus.cdb_rob_index[p*IDXW +: IDXW];
                if (bus.cdb_valid[p] && valid_q[cidx]) begin
                    done_d[cidx] = 1'b1;
                    mis_d[cidx]  = mis_d[cidx] | bus.cdb_branch_mismatch[p];
                end
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (lane_vld[i]) begin
                    valid_d[lane_idx[i]] = 1'b0;
                    done_d[lane_idx[i]]  = 1'b0;
                    mis_d[lane_idx[i]]   = 1'b0;
                end
            end
            head_d = head_q + ncommit;
            if (enq_fire) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                mis_d[tail_idx]   = 1'b0;
                tail_d            = tail_q + PTRW'(1);
            end
        end
    end

    // Control state: pointers and per-entry status bits, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            mis_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

    // Entry payload: written on allocation only; never read unless the entry is occupied.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_q[tail_idx]   <= bus.enq_pc;
            inst_q[tail_idx] <= bus.enq_inst;
            arch_q[tail_idx] <= bus.enq_arch_rd;
            phys_q[tail_idx] <= bus.enq_phys_rd;
        end
    end

    // Outputs read as zero while reset is held (commit lanes are already gated by rst).
    assign bus.enq_ready      = enq_ready;
    assign bus.enq_index      = rst ? '0 : tail_idx;
    assign bus.count          = rst ? '0 : occ;
    assign bus.commit_valid   = lane_vld;
    assign bus.commit_arch_rd = c_arch;
    assign bus.commit_phys_rd = c_phys;
    assign bus.commit_pc      = c_pc;
    assign bus.commit_inst    = c_inst;
    assign bus.flush          = flush;
endmodule
